axi_lite_cfg_slave: RTL and testbench
=====================================

# axi_lite_cfg_slave

AXI-Lite slave register file that answers the configuration master of the up-sampling accelerator. It holds frame geometry and control bits, issues a one-cycle start pulse to access control, collects the completion pulse, and drives the `interrupt_updone` output. It sits between the host configuration bus and the up-sampling/access-control datapath, one outstanding transaction per direction.

## Interface
- `ADDR_W`, 12: AXI-Lite address width; decode uses `addr[5:2]`, upper bits must be zero.
- `DATA_W`, 32: data width; fixed at 32, other values unsupported.
- `ID_VALUE`, 32'h5352_0001: constant returned by the ID register.
- `aclk` in 1: the block's one clock.
- `arstn` in 1: reset, asynchronous and active-low.
- `awaddr` in ADDR_W, `awvalid` in 1, `awready` out 1: write address channel.
- `wdata` in 32, `wstrb` in 4, `wvalid` in 1, `wready` out 1: write data channel.
- `bresp` out 2, `bvalid` out 1, `bready` in 1: write response channel.
- `araddr` in ADDR_W, `arvalid` in 1, `arready` out 1: read address channel.
- `rdata` out 32, `rresp` out 2, `rvalid` out 1, `rready` in 1: read data channel.
- `cfg_start` out 1: one-cycle start pulse to access control.
- `cfg_width` out 16, `cfg_height` out 16: input frame geometry.
- `up_busy` in 1: datapath busy level.
- `up_done` in 1: one-cycle completion pulse.
- `interrupt_updone` out 1: level interrupt, registered.

## Operation
- Register map (byte offsets):
  - 0x00 CTRL: bit0 START, write-1 pulses `cfg_start`, reads 0.
  - 0x04 STATUS: bit0 BUSY (RO, `up_busy`); bit1 DONE (sticky, set by `up_done`, write-1-clear).
  - 0x08 WIDTH[15:0], reset 960.
  - 0x0C HEIGHT[15:0], reset 540.
  - 0x10 INT_EN bit0, reset 0.
  - 0x14 ID: RO `ID_VALUE`.
- Unused bits read 0; writes to RO fields are ignored.
- `wstrb` is honoured per byte on WIDTH and HEIGHT. CTRL, STATUS and INT_EN act only when `wstrb[0]=1`.
- Unmapped offset, or non-zero `addr[ADDR_W-1:6]`: no register effect, response SLVERR (2'b10), `rdata`=0. Otherwise OKAY (2'b00).
- START written while `up_busy`=1 is ignored; response is still OKAY.
- `interrupt_updone` = DONE & INT_EN, registered one cycle.

## Timing
- Reset values: `awready`=1, `wready`=1, `arready`=1, `bvalid`=0, `rvalid`=0, `bresp`=0, `rresp`=0, `rdata`=0, `cfg_start`=0, `interrupt_updone`=0. Registers take their map reset values.
- AW and W are captured independently, in any order or in the same cycle. Each ready drops after its own capture and stays low until the B handshake.
- Write FSM: IDLE -> (one channel captured) WAIT_OTHER -> (both held) COMMIT -> RESP -> (`bvalid` & `bready`) IDLE.
  - COMMIT lasts one cycle. The register update and `cfg_start` occur on the COMMIT edge, and `bvalid` rises on that same edge.
  - `bvalid` and `bresp` hold until `bready`.
- Read: an `arvalid` & `arready` edge registers `rdata`/`rresp` and sets `rvalid` on the next edge. `arready`=0 while `rvalid`=1. Data holds until `rready`.
- A read of a register being written in the same cycle returns the old value.
- If `up_done` and a DONE W1C land on the same edge, set wins and DONE stays 1.
- `arstn` mid-transaction: all channels return to reset values immediately and pending responses are dropped.

## Structure
- Package `cfg_regs_pkg`: register offsets, field bit positions, reset values (960/540), the `axi_resp_t` enum (OKAY, SLVERR), and the write FSM state enum.
- No sub-module. Write FSM, read path and register bank stay flat in one module.

## Test plan
- Reset and read: after reset, read 0x08 -> 960 OKAY; 0x0C -> 540; 0x14 -> 32'h5352_0001.
- Write ordering: W one cycle before AW, then AW before W, then both in the same cycle, each writing 0x08=1920 -> `bvalid` one cycle after the final handshake; readback 1920.
- Partial strobe: 0x0C=32'h0000_ABCD with `wstrb`=4'b0001, prior value 540 (0x021C) -> reads 0x02CD.
- Start while busy: START with `up_busy`=0 -> `cfg_start` high exactly one cycle. START with `up_busy`=1 -> no pulse, OKAY.
- DONE and interrupt: INT_EN=1, pulse `up_done` -> `interrupt_updone`=1 within 2 cycles. W1C to STATUS on the same edge as a new `up_done` -> DONE stays 1. Later W1C -> interrupt clears.
- Error and backpressure: write 0x20 -> SLVERR, no register changes. Hold `bready`/`rready` low 5 cycles -> `bvalid`/`rvalid`, data and responses stable, and `awready`/`arready` stay low.

Source files
------------

// File: rtl/cfg_regs_pkg.sv
// Register map, field positions, reset values and shared enums for the
// up-sampler configuration slave.
package cfg_regs_pkg;

    // Word indices (byte offset >> 2) of the mapped registers.
    localparam logic [3:0] IDX_CTRL   = 4'd0;
    localparam logic [3:0] IDX_STATUS = 4'd1;
    localparam logic [3:0] IDX_WIDTH  = 4'd2;
    localparam logic [3:0] IDX_HEIGHT = 4'd3;
    localparam logic [3:0] IDX_INT_EN = 4'd4;
    localparam logic [3:0] IDX_ID     = 4'd5;

    localparam int CTRL_START_BIT  = 0;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int INT_EN_BIT      = 0;

    localparam logic [15:0] WIDTH_RESET  = 16'd960;
    localparam logic [15:0] HEIGHT_RESET = 16'd540;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_WAIT_OTHER,
        WR_COMMIT,
        WR_RESP
    } wr_state_t;

    function automatic logic idx_mapped(input logic [3:0] idx);
        return idx <= IDX_ID;
    endfunction

endpackage

// File: rtl/axi_lite_cfg_slave_if.sv
// AXI-Lite bus bundle between the host configuration master and the
// up-sampler register slave.
interface axi_lite_cfg_slave_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_cfg_slave.sv
// AXI-Lite register file for the up-sampling accelerator: frame geometry,
// start pulse, sticky DONE with interrupt, one transaction per direction.
module axi_lite_cfg_slave
    import cfg_regs_pkg::*;
#(
    parameter int          ADDR_W   = 12,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] ID_VALUE = 32'h5352_0001
) (
    input  logic                aclk,
    input  logic                arstn,
    axi_lite_cfg_slave_if.slave bus,
    output logic                cfg_start,
    output logic [15:0]         cfg_width,
    output logic [15:0]         cfg_height,
    input  logic                up_busy,
    input  logic                up_done,
    output logic                interrupt_updone
);

    wr_state_t         state_q, state_d;
    logic              aw_held_q, w_held_q;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [15:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic              aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic              aw_have, w_have;

    logic [15:0]       width_q, height_q;
    logic              int_en_q, done_q, start_q, irq_q;
    logic              bvalid_q, rvalid_q;
    axi_resp_t         bresp_q, rresp_q, rd_resp_d;
    logic [DATA_W-1:0] rdata_q, rd_data_d;

    logic [3:0]        wr_idx, rd_idx;
    logic              wr_ok, commit, start_req, done_clr;

    // Readies are free whenever the channel has nothing parked.
    assign aw_fire = bus.awvalid & ~aw_held_q;
    assign w_fire  = bus.wvalid  & ~w_held_q;
    assign b_fire  = bvalid_q    & bus.bready;
    assign ar_fire = bus.arvalid & ~rvalid_q;
    assign r_fire  = rvalid_q    & bus.rready;
    assign aw_have = aw_held_q | aw_fire;
    assign w_have  = w_held_q  | w_fire;

    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge value of its peers; blocking = here would chain them.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) state_q <= WR_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d takes a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WR_IDLE: begin
                if (aw_have && w_have)     state_d = WR_COMMIT;
                else if (aw_fire || w_fire) state_d = WR_WAIT_OTHER;
            end
            WR_WAIT_OTHER: if (aw_have && w_have) state_d = WR_COMMIT;
            WR_COMMIT:     state_d = WR_RESP;
            WR_RESP:       if (b_fire) state_d = WR_IDLE;
            default:       state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (aw_fire) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= bus.awaddr;
            end else if (b_fire) begin
                aw_held_q <= 1'b0;
            end
            if (w_fire) begin
                w_held_q <= 1'b1;
                w_data_q <= bus.wdata[15:0];
                w_strb_q <= bus.wstrb;
            end else if (b_fire) begin
                w_held_q <= 1'b0;
            end
        end
    end

    assign commit    = (state_q == WR_COMMIT);
    assign wr_idx    = aw_addr_q[5:2];
    assign wr_ok     = ~|aw_addr_q[ADDR_W-1:6] & idx_mapped(wr_idx);
    assign start_req = commit & wr_ok & (wr_idx == IDX_CTRL) & w_strb_q[0]
                     & w_data_q[CTRL_START_BIT] & ~up_busy;
    assign done_clr  = commit & wr_ok & (wr_idx == IDX_STATUS) & w_strb_q[0]
                     & w_data_q[STATUS_DONE_BIT];

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            width_q  <= WIDTH_RESET;
            height_q <= HEIGHT_RESET;
            int_en_q <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            irq_q    <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            start_q <= start_req;
            irq_q   <= done_q & int_en_q;
            // A completion landing with the clear keeps DONE set.
            done_q  <= up_done | (done_q & ~done_clr);
            if (commit && wr_ok) begin
                case (wr_idx)
                    IDX_WIDTH: begin
                        if (w_strb_q[0]) width_q[7:0]  <= w_data_q[7:0];
                        if (w_strb_q[1]) width_q[15:8] <= w_data_q[15:8];
                    end
                    IDX_HEIGHT: begin
                        if (w_strb_q[0]) height_q[7:0]  <= w_data_q[7:0];
                        if (w_strb_q[1]) height_q[15:8] <= w_data_q[15:8];
                    end
                    IDX_INT_EN: if (w_strb_q[0]) int_en_q <= w_data_q[INT_EN_BIT];
                    default: ;
                endcase
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (b_fire) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    assign rd_idx = bus.araddr[5:2];

    always_comb begin
        rd_data_d = '0;
        rd_resp_d = RESP_SLVERR;
        if (~|bus.araddr[ADDR_W-1:6] && idx_mapped(rd_idx)) begin
            rd_resp_d = RESP_OKAY;
            case (rd_idx)
                IDX_STATUS: begin
                    rd_data_d[STATUS_BUSY_BIT] = up_busy;
                    rd_data_d[STATUS_DONE_BIT] = done_q;
                end
                IDX_WIDTH:  rd_data_d[15:0]       = width_q;
                IDX_HEIGHT: rd_data_d[15:0]       = height_q;
                IDX_INT_EN: rd_data_d[INT_EN_BIT] = int_en_q;
                IDX_ID:     rd_data_d             = ID_VALUE;
                default: ;
            endcase
        end
    end

    // Read data is taken from the pre-edge register values, so a write
    // committing on the same edge is not yet visible.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data_d;
            rresp_q  <= rd_resp_d;
        end else if (r_fire) begin
            rvalid_q <= 1'b0;
        end
    end

    assign bus.awready      = ~aw_held_q;
    assign bus.wready       = ~w_held_q;
    assign bus.bvalid       = bvalid_q;
    assign bus.bresp        = bresp_q;
    assign bus.arready      = ~rvalid_q;
    assign bus.rvalid       = rvalid_q;
    assign bus.rresp        = rresp_q;
    assign bus.rdata        = rdata_q;
    assign cfg_start        = start_q;
    assign cfg_width        = width_q;
    assign cfg_height       = height_q;
    assign interrupt_updone = irq_q;

    logic unused_bits;
    assign unused_bits = ^{aw_addr_q[1:0], bus.araddr[1:0], bus.wdata[31:16], w_strb_q[3:2]};

endmodule

// File: tb/tb_axi_lite_cfg_slave.sv
// Bench for axi_lite_cfg_slave: directed register-map cases plus a random
// phase, all compared each cycle against a transaction-level model.
module tb_axi_lite_cfg_slave;

    logic        aclk = 1'b0;
    logic        arstn = 1'b0;
    logic        cfg_start;
    logic [15:0] cfg_width, cfg_height;
    logic        up_busy, up_done, interrupt_updone;

    always #5 aclk = ~aclk;

    axi_lite_cfg_slave_if #(.ADDR_W(12)) bus ();

    axi_lite_cfg_slave #(.ADDR_W(12), .DATA_W(32), .ID_VALUE(32'h5352_0001)) dut (
        .aclk             (aclk),
        .arstn            (arstn),
        .bus              (bus),
        .cfg_start        (cfg_start),
        .cfg_width        (cfg_width),
        .cfg_height       (cfg_height),
        .up_busy          (up_busy),
        .up_done          (up_done),
        .interrupt_updone (interrupt_updone)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_width, m_height;
    logic        m_int_en, m_done;
    bit          m_aw_have, m_w_have, m_commit_pending;
    logic [11:0] m_aw_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    bit          e_bvalid, e_rvalid, e_start, e_irq;
    logic [1:0]  e_bresp, e_rresp;
    logic [31:0] e_rdata;
    bit          aw_f, w_f, ar_f, b_f, r_f;
    int          start_count = 0;

    task automatic model_reset();
        m_width = 16'd960; m_height = 16'd540; m_int_en = 0; m_done = 0;
        m_aw_have = 0; m_w_have = 0; m_commit_pending = 0;
        e_bvalid = 0; e_rvalid = 0; e_start = 0; e_irq = 0;
        e_bresp = 0; e_rresp = 0; e_rdata = 0;
        aw_f = 0; w_f = 0; ar_f = 0; b_f = 0; r_f = 0;
    endtask

    function automatic logic [33:0] model_read(input logic [11:0] a);
        if (a[11:6] != 0) return {2'b10, 32'h0};
        case (a[5:2])
            4'd0: return {2'b00, 32'h0};
            4'd1: return {2'b00, 30'h0, m_done, up_busy};
            4'd2: return {2'b00, 16'h0, m_width};
            4'd3: return {2'b00, 16'h0, m_height};
            4'd4: return {2'b00, 31'h0, m_int_en};
            4'd5: return {2'b00, 32'h5352_0001};
            default: return {2'b10, 32'h0};
        endcase
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic w1c, output logic st, output logic [1:0] resp);
        w1c = 0; st = 0; resp = 2'b10;
        if (a[11:6] == 0 && a[5:2] <= 4'd5) begin
            resp = 2'b00;
            case (a[5:2])
                4'd0: st = s[0] & d[0] & ~up_busy;
                4'd1: w1c = s[0] & d[1];
                4'd2: begin
                    if (s[0]) m_width[7:0] = d[7:0];
                    if (s[1]) m_width[15:8] = d[15:8];
                end
                4'd3: begin
                    if (s[0]) m_height[7:0] = d[7:0];
                    if (s[1]) m_height[15:8] = d[15:8];
                end
                4'd4: if (s[0]) m_int_en = d[0];
                default: ;
            endcase
        end
    endtask

    // Compare on the falling edge, then advance the model to the next rising edge.
    always @(negedge aclk) begin
        logic od, oi, w1c, st;
        logic [33:0] rr;
        if (!arstn) begin
            model_reset();
            check("rst_awready", bus.awready, 1);
            check("rst_wready", bus.wready, 1);
            check("rst_arready", bus.arready, 1);
            check("rst_bvalid", bus.bvalid, 0);
            check("rst_rvalid", bus.rvalid, 0);
            check("rst_bresp", bus.bresp, 0);
            check("rst_rresp", bus.rresp, 0);
            check("rst_rdata", bus.rdata, 0);
            check("rst_cfg_start", cfg_start, 0);
            check("rst_irq", interrupt_updone, 0);
        end else begin
            check("awready", bus.awready, !m_aw_have);
            check("wready", bus.wready, !m_w_have);
            check("arready", bus.arready, !e_rvalid);
            check("bvalid", bus.bvalid, e_bvalid);
            check("rvalid", bus.rvalid, e_rvalid);
            if (e_bvalid) check("bresp", bus.bresp, e_bresp);
            if (e_rvalid) begin
                check("rdata", bus.rdata, e_rdata);
                check("rresp", bus.rresp, e_rresp);
            end
            check("cfg_start", cfg_start, e_start);
            check("irq", interrupt_updone, e_irq);
            check("cfg_width", cfg_width, m_width);
            check("cfg_height", cfg_height, m_height);
            if (cfg_start) start_count++;

            aw_f = bus.awvalid && !m_aw_have;
            w_f  = bus.wvalid && !m_w_have;
            ar_f = bus.arvalid && !e_rvalid;
            r_f  = e_rvalid && bus.rready;
            b_f  = e_bvalid && bus.bready;
            od = m_done; oi = m_int_en;
            if (ar_f) begin
                rr = model_read(bus.araddr);
                e_rresp = rr[33:32]; e_rdata = rr[31:0]; e_rvalid = 1;
            end else if (r_f) begin
                e_rvalid = 0;
            end
            w1c = 0; st = 0;
            if (m_commit_pending) begin
                model_write(m_aw_addr, m_wdata, m_wstrb, w1c, st, e_bresp);
                e_bvalid = 1; m_commit_pending = 0;
            end else if (b_f) begin
                e_bvalid = 0; m_aw_have = 0; m_w_have = 0;
            end
            e_start = st;
            e_irq = od & oi;
            m_done = up_done ? 1'b1 : (w1c ? 1'b0 : od);
            if (aw_f) begin m_aw_have = 1; m_aw_addr = bus.awaddr; end
            if (w_f) begin m_w_have = 1; m_wdata = bus.wdata; m_wstrb = bus.wstrb; end
            if ((aw_f || w_f) && m_aw_have && m_w_have) m_commit_pending = 1;
        end
    end

    // ---------------- directed transaction tasks ----------------
    // mode 0: W then AW, 1: AW then W, 2: same cycle.
    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, input int mode,
                      input bit done_at_commit, input int hold_b, input logic [1:0] exp_resp, input string name);
        bit aw_done = 0, w_done = 0;
        int n = 0;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s; bus.bready = 0;
        if (mode != 1) bus.wvalid = 1;
        if (mode != 0) bus.awvalid = 1;
        while (!(aw_done && w_done) && n < 20) begin
            @(posedge aclk); #1; n++;
            if (aw_f) begin aw_done = 1; bus.awvalid = 0; end
            if (w_f)  begin w_done = 1;  bus.wvalid = 0; end
            if (mode == 0 && w_done && !aw_done) bus.awvalid = 1;
            if (mode == 1 && aw_done && !w_done) bus.wvalid = 1;
        end
        if (!(aw_done && w_done)) check({name, "_handshake_timeout"}, 0, 1);
        if (done_at_commit) up_done = 1;
        check({name, "_bvalid_early"}, bus.bvalid, 0);
        @(posedge aclk); #1;
        up_done = 0;
        check({name, "_bvalid"}, bus.bvalid, 1);
        check({name, "_bresp"}, bus.bresp, exp_resp);
        repeat (hold_b) begin
            @(posedge aclk); #1;
            check({name, "_hold_bvalid"}, bus.bvalid, 1);
            check({name, "_hold_bresp"}, bus.bresp, exp_resp);
            check({name, "_hold_awready"}, bus.awready, 0);
            check({name, "_hold_wready"}, bus.wready, 0);
        end
        bus.bready = 1;
        @(posedge aclk); #1;
        bus.bready = 0;
        check({name, "_bvalid_done"}, bus.bvalid, 0);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                      input int hold_r, input string name);
        int n = 0;
        bus.araddr = a; bus.arvalid = 1; bus.rready = 0;
        do begin
            @(posedge aclk); #1; n++;
        end while (!ar_f && n < 20);
        bus.arvalid = 0;
        if (!ar_f) check({name, "_ar_timeout"}, 0, 1);
        check({name, "_rvalid"}, bus.rvalid, 1);
        check({name, "_rdata"}, bus.rdata, exp_d);
        check({name, "_rresp"}, bus.rresp, exp_r);
        repeat (hold_r) begin
            @(posedge aclk); #1;
            check({name, "_hold_rvalid"}, bus.rvalid, 1);
            check({name, "_hold_rdata"}, bus.rdata, exp_d);
            check({name, "_hold_rresp"}, bus.rresp, exp_r);
            check({name, "_hold_arready"}, bus.arready, 0);
        end
        bus.rready = 1;
        @(posedge aclk); #1;
        bus.rready = 0;
    endtask

    function automatic logic [11:0] rand_addr();
        case ($urandom_range(10))
            0: return 12'h000;
            1: return 12'h004;
            2: return 12'h008;
            3: return 12'h00C;
            4: return 12'h010;
            5: return 12'h014;
            6: return 12'h018;
            7: return 12'h020;
            8: return 12'h108;
            9: return 12'h008;
            default: return 12'h004;
        endcase
    endfunction

    initial begin
        int sc0, n;
        bus.awaddr = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0;
        bus.bready = 0; bus.araddr = 0; bus.arvalid = 0; bus.rready = 0;
        up_busy = 0; up_done = 0;

        repeat (3) @(negedge aclk);
        #1;
        check("reset_width", cfg_width, 16'd960);
        check("reset_height", cfg_height, 16'd540);
        @(posedge aclk); #1;
        arstn = 1;

        rd(12'h008, 32'd960, 2'b00, 0, "rd_width_reset");
        rd(12'h00C, 32'd540, 2'b00, 0, "rd_height_reset");
        rd(12'h014, 32'h5352_0001, 2'b00, 0, "rd_id");

        wr(12'h008, 32'd1920, 4'hF, 0, 0, 0, 2'b00, "wr_w_first");
        rd(12'h008, 32'd1920, 2'b00, 0, "rb_w_first");
        wr(12'h008, 32'd1280, 4'hF, 1, 0, 0, 2'b00, "wr_aw_first");
        rd(12'h008, 32'd1280, 2'b00, 0, "rb_aw_first");
        wr(12'h008, 32'd1920, 4'hF, 2, 0, 0, 2'b00, "wr_same");
        rd(12'h008, 32'd1920, 2'b00, 0, "rb_same");

        wr(12'h00C, 32'h0000_ABCD, 4'b0001, 2, 0, 0, 2'b00, "wr_strobe");
        rd(12'h00C, 32'h0000_02CD, 2'b00, 0, "rb_strobe");

        sc0 = start_count;
        wr(12'h000, 32'h1, 4'h1, 2, 0, 0, 2'b00, "wr_start");
        repeat (2) @(posedge aclk);
        #1;
        check("start_pulses", start_count - sc0, 1);
        up_busy = 1;
        sc0 = start_count;
        wr(12'h000, 32'h1, 4'h1, 2, 0, 0, 2'b00, "wr_start_busy");
        repeat (2) @(posedge aclk);
        #1;
        check("start_busy_pulses", start_count - sc0, 0);
        up_busy = 0;

        wr(12'h010, 32'h1, 4'h1, 2, 0, 0, 2'b00, "wr_int_en");
        up_done = 1;
        @(posedge aclk); #1;
        up_done = 0;
        n = 0;
        while (!interrupt_updone && n < 2) begin @(posedge aclk); #1; n++; end
        check("irq_set", interrupt_updone, 1);
        wr(12'h004, 32'h2, 4'h1, 2, 1, 0, 2'b00, "wr_w1c_vs_done");
        rd(12'h004, 32'h2, 2'b00, 0, "rb_done_kept");
        check("irq_kept", interrupt_updone, 1);
        wr(12'h004, 32'h2, 4'h1, 2, 0, 0, 2'b00, "wr_w1c");
        repeat (2) @(posedge aclk);
        #1;
        check("irq_cleared", interrupt_updone, 0);
        rd(12'h004, 32'h0, 2'b00, 0, "rb_done_cleared");

        wr(12'h020, 32'hFFFF_FFFF, 4'hF, 2, 0, 0, 2'b10, "wr_unmapped");
        wr(12'h108, 32'h0000_0055, 4'hF, 2, 0, 0, 2'b10, "wr_upper_bits");
        rd(12'h008, 32'd1920, 2'b00, 0, "rb_after_err");
        rd(12'h020, 32'h0, 2'b10, 0, "rd_unmapped");

        wr(12'h00C, 32'h0000_1234, 4'hF, 2, 0, 5, 2'b00, "wr_backpressure");
        rd(12'h00C, 32'h0000_1234, 2'b00, 5, "rd_backpressure");

        for (int c = 0; c < 2500; c++) begin
            @(posedge aclk); #1;
            if (bus.awvalid && aw_f) bus.awvalid = 0;
            if (!bus.awvalid && $urandom_range(3) == 0) begin
                bus.awvalid = 1; bus.awaddr = rand_addr();
            end
            if (bus.wvalid && w_f) bus.wvalid = 0;
            if (!bus.wvalid && $urandom_range(3) == 0) begin
                bus.wvalid = 1; bus.wdata = $urandom; bus.wstrb = 4'($urandom);
            end
            if (bus.arvalid && ar_f) bus.arvalid = 0;
            if (!bus.arvalid && $urandom_range(2) == 0) begin
                bus.arvalid = 1; bus.araddr = rand_addr();
            end
            bus.bready = 1'($urandom_range(1));
            bus.rready = 1'($urandom_range(1));
            up_done = ($urandom_range(7) == 0);
            if ($urandom_range(15) == 0) up_busy = ~up_busy;
        end

        #2;
        arstn = 0;
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        bus.bready = 0; bus.rready = 0; up_done = 0; up_busy = 0;
        #1;
        check("async_rst_awready", bus.awready, 1);
        check("async_rst_wready", bus.wready, 1);
        check("async_rst_arready", bus.arready, 1);
        check("async_rst_bvalid", bus.bvalid, 0);
        check("async_rst_rvalid", bus.rvalid, 0);
        check("async_rst_width", cfg_width, 16'd960);
        repeat (2) @(negedge aclk);
        @(posedge aclk); #1;
        arstn = 1;
        rd(12'h008, 32'd960, 2'b00, 0, "rd_after_async_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
